// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: bus widths, CP0 numbering,
// exception codes and the packed layout of the memory-to-writeback bus.
package wb_stage_pkg;
  localparam int MS_TO_WS_BUS_WD = 117;
  localparam int WS_FWD_BUS_WD   = 39;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc0_0380;

  typedef struct packed {
    logic        ex;
    logic        eret;
    logic        bd;
    logic [4:0]  excode;
    logic [4:0]  rt;
    logic        mfc0;
    logic        mtc0;
    logic [31:0] rt_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_bus_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } cp0_wr_t;

  typedef struct packed {
    logic        ex;
    logic        eret;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] pc;
  } cp0_exc_t;

  // EPC points at the branch when the faulting instruction sits in a delay slot.
  function automatic logic [31:0] exc_epc(input logic bd, input logic [31:0] pc);
    return bd ? pc - 32'd4 : pc;
  endfunction
endpackage

// File: rtl/wb_stage_cp0.sv
// CP0 register file: Status/Cause/EPC/Count/Compare, timer interrupt,
// exception/eret state updates and the mfc0 read mux.
module cp0_regs
  import wb_stage_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  cp0_wr_t     wr,
  input  cp0_exc_t    exc,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        int_pending
);
  localparam logic DIV1 = (COUNT_DIV == 1);

  logic [7:0]  im;
  logic        exl, ie;
  logic        bd, ti;
  logic [1:0]  ip_sw;
  logic [4:0]  excode;
  logic [31:0] count, compare;
  logic        tick;
  logic [7:0]  ip;

  logic wr_status, wr_cause, wr_epc, wr_count, wr_compare;
  assign wr_status  = wr.we && wr.addr == CP0_STATUS;
  assign wr_cause   = wr.we && wr.addr == CP0_CAUSE;
  assign wr_epc     = wr.we && wr.addr == CP0_EPC;
  assign wr_count   = wr.we && wr.addr == CP0_COUNT;
  assign wr_compare = wr.we && wr.addr == CP0_COMPARE;

  always_ff @(posedge clk) begin
    if (reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else begin
      if (wr_status) begin
        im  <= wr.wdata[15:8];
        exl <= wr.wdata[1];
        ie  <= wr.wdata[0];
      end
      if (exc.ex)        exl <= 1'b1;
      else if (exc.eret) exl <= 1'b0;
    end
  end

  // A nested exception (EXL already set) keeps the original BD and EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      bd     <= 1'b0;
      ip_sw  <= '0;
      excode <= '0;
      epc    <= '0;
    end else begin
      if (wr_cause) ip_sw <= wr.wdata[9:8];
      if (wr_epc)   epc   <= wr.wdata;
      if (exc.ex) begin
        excode <= exc.code;
        if (!exl) begin
          bd  <= exc.bd;
          epc <= exc_epc(exc.bd, exc.pc);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (wr_count) begin
      count <= wr.wdata;
      tick  <= 1'b0;
    end else begin
      if (DIV1 || tick) count <= count + 32'd1;
      tick <= DIV1 ? 1'b1 : ~tick;
    end
  end

  // TI is sticky until software rewrites Compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      compare <= '0;
      ti      <= 1'b0;
    end else if (wr_compare) begin
      compare <= wr.wdata;
      ti      <= 1'b0;
    end else if (count == compare) begin
      ti <= 1'b1;
    end
  end

  assign ip          = {ti, 5'b0, ip_sw};
  assign int_pending = ie & ~exl & (|(ip & im));

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_COUNT:   rdata = count;
      CP0_COMPARE: rdata = compare;
      CP0_STATUS:  rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      CP0_CAUSE:   rdata = {bd, ti, 14'b0, ip, 1'b0, excode, 2'b0};
      CP0_EPC:     rdata = epc;
      default:     rdata = '0;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts the memory-stage bus, commits GPR writes,
// drives CP0 access and raises the flush/redirect for exceptions and eret.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY  = EX_ENTRY_DEF,
  parameter int          COUNT_DIV = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ws_allowin,
  output logic                       ws_to_ms_bus,
  output logic                       ws_flush,
  output logic [31:0]                ws_flush_pc,
  output logic                       ws_int_pending,
  output logic [WS_FWD_BUS_WD-1:0]   ws_fwd_bus,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);
  logic        ws_valid;
  logic        ready_go;
  ms_bus_t     ws;
  cp0_wr_t     cp0_wr;
  cp0_exc_t    cp0_exc;
  logic [31:0] cp0_rdata, cp0_epc;

  assign ready_go   = 1'b1;
  assign ws_allowin = ~ws_valid | ready_go;

  // Younger instruction arriving behind a flushing one is dropped.
  always_ff @(posedge clk) begin
    if (reset)           ws_valid <= 1'b0;
    else if (ws_allowin) ws_valid <= ms_to_ws_valid & ~ws_flush;
  end

  always_ff @(posedge clk) begin
    if (reset)                            ws <= '0;
    else if (ms_to_ws_valid & ws_allowin) ws <= ms_to_ws_bus;
  end

  assign cp0_wr.we     = ws_valid & ws.mtc0 & ~ws.ex;
  assign cp0_wr.addr   = ws.dest;
  assign cp0_wr.wdata  = ws.rt_value;
  assign cp0_exc.ex    = ws_valid & ws.ex;
  assign cp0_exc.eret  = ws_valid & ws.eret & ~ws.ex;
  assign cp0_exc.bd    = ws.bd;
  assign cp0_exc.code  = ws.excode;
  assign cp0_exc.pc    = ws.pc;

  cp0_regs #(.COUNT_DIV(COUNT_DIV)) u_cp0 (
    .clk         (clk),
    .reset       (reset),
    .wr          (cp0_wr),
    .exc         (cp0_exc),
    .raddr       (ws.dest),
    .rdata       (cp0_rdata),
    .epc         (cp0_epc),
    .int_pending (ws_int_pending)
  );

  // Gated by reset so an instruction caught by reset neither commits nor redirects.
  assign ws_flush     = ws_valid & (ws.ex | ws.eret) & ~reset;
  assign ws_to_ms_bus = ws_flush;
  assign ws_flush_pc  = ws.ex ? EX_ENTRY : cp0_epc;

  assign rf_we    = ws_valid & ~ws.ex & ~reset &
                    (ws.mfc0 ? (ws.rt != 5'd0) : (ws.gr_we & (ws.dest != 5'd0)));
  assign rf_waddr = ws.mfc0 ? ws.rt : ws.dest;
  assign rf_wdata = ws.mfc0 ? cp0_rdata : ws.result;

  assign ws_fwd_bus = {ws.mfc0 & ws_valid, rf_wdata, rf_we, rf_waddr};

  assign debug_wb_pc       = ws_valid ? ws.pc : 32'd0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a cycle-level architectural model predicts
// each cycle's outputs; a negedge monitor pops and compares them.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic [116:0] ms_to_ws_bus;
  logic        ws_allowin, ws_to_ms_bus, ws_flush, ws_int_pending, rf_we;
  logic [31:0] ws_flush_pc, rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [38:0] ws_fwd_bus;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [3:0]  debug_wb_rf_wen;

  wb_stage dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .ws_to_ms_bus(ws_to_ms_bus), .ws_flush(ws_flush),
    .ws_flush_pc(ws_flush_pc), .ws_int_pending(ws_int_pending), .ws_fwd_bus(ws_fwd_bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [31:0] fpc;
    logic        intp;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] dpc;
    logic        fmfc0;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // architectural model
  logic        m_valid;
  ms_bus_t     m_bus;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti, m_tick;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_count, m_cmp;

  task automatic model_reset();
    m_valid = 0; m_bus = '0; m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_tick = 0; m_ipsw = 0; m_code = 0; m_epc = 0; m_count = 0; m_cmp = 0;
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      5'd9:  v = m_count;
      5'd11: v = m_cmp;
      5'd12: begin v = 32'h0040_0000; v[15:8] = m_im; v[1] = m_exl; v[0] = m_ie; end
      5'd13: begin v[31] = m_bd; v[30] = m_ti; v[15] = m_ti; v[9:8] = m_ipsw; v[6:2] = m_code; end
      5'd14: v = m_epc;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // One clock: drive inputs, push this cycle's expected outputs, advance model.
  task automatic cyc(input logic rst, input logic v, input ms_bus_t b);
    exp_t e;
    logic fl, exo, mt, er;
    logic [31:0] wd;
    @(posedge clk); #1;
    reset = rst; ms_to_ws_valid = v; ms_to_ws_bus = b;
    exo     = m_valid & m_bus.ex;
    fl      = m_valid & (m_bus.ex | m_bus.eret) & !rst;
    e.flush = fl;
    e.fpc   = m_bus.ex ? 32'hbfc0_0380 : m_epc;
    e.intp  = m_ie & !m_exl & ((m_ti & m_im[7]) | (|(m_ipsw & m_im[1:0])));
    e.we    = m_valid & !m_bus.ex & !rst &
              (m_bus.mfc0 ? (m_bus.rt != 0) : (m_bus.gr_we & (m_bus.dest != 0)));
    e.wa    = m_bus.mfc0 ? m_bus.rt : m_bus.dest;
    e.wd    = m_bus.mfc0 ? m_rd(m_bus.dest) : m_bus.result;
    e.dpc   = m_valid ? m_bus.pc : 32'd0;
    e.fmfc0 = m_valid & m_bus.mfc0;
    q.push_back(e);
    if (rst) model_reset();
    else begin
      mt = m_valid & m_bus.mtc0 & !m_bus.ex;
      er = m_valid & m_bus.eret & !m_bus.ex;
      wd = m_bus.rt_value;
      if (mt && m_bus.dest == 11) m_ti = 0;
      else if (m_count == m_cmp) m_ti = 1;
      if (mt && m_bus.dest == 9) begin m_count = wd; m_tick = 0; end
      else begin if (m_tick) m_count = m_count + 1; m_tick = !m_tick; end
      if (mt && m_bus.dest == 11) m_cmp = wd;
      if (mt && m_bus.dest == 12) begin m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0]; end
      if (mt && m_bus.dest == 13) m_ipsw = wd[9:8];
      if (mt && m_bus.dest == 14) m_epc = wd;
      if (exo) begin
        if (!m_exl) begin m_bd = m_bus.bd; m_epc = m_bus.bd ? m_bus.pc - 4 : m_bus.pc; end
        m_code = m_bus.excode; m_exl = 1;
      end else if (er) m_exl = 0;
      m_valid = v & !fl;
      if (v) m_bus = b;
    end
  endtask

  function automatic ms_bus_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    ms_bus_t b; b = '0; b.pc = pc; b.dest = d; b.result = r; b.gr_we = 1; return b;
  endfunction
  function automatic ms_bus_t mtc0_i(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] val);
    ms_bus_t b; b = '0; b.pc = pc; b.mtc0 = 1; b.dest = r; b.rt_value = val; return b;
  endfunction
  function automatic ms_bus_t mfc0_i(input logic [31:0] pc, input logic [4:0] rt, input logic [4:0] r);
    ms_bus_t b; b = '0; b.pc = pc; b.mfc0 = 1; b.gr_we = 1; b.rt = rt; b.dest = r; return b;
  endfunction
  function automatic ms_bus_t exc_i(input logic [31:0] pc, input logic [4:0] code, input logic bd);
    ms_bus_t b; b = '0; b.pc = pc; b.ex = 1; b.excode = code; b.bd = bd; return b;
  endfunction
  function automatic ms_bus_t eret_i(input logic [31:0] pc);
    ms_bus_t b; b = '0; b.pc = pc; b.eret = 1; return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("allowin", {31'b0, ws_allowin}, 32'd1);
      chk("flush", {31'b0, ws_flush}, {31'b0, e.flush});
      chk("ws_to_ms", {31'b0, ws_to_ms_bus}, {31'b0, e.flush});
      if (e.flush) chk("flush_pc", ws_flush_pc, e.fpc);
      chk("int_pending", {31'b0, ws_int_pending}, {31'b0, e.intp});
      chk("rf_we", {31'b0, rf_we}, {31'b0, e.we});
      chk("dbg_wen", {28'b0, debug_wb_rf_wen}, {28'b0, {4{e.we}}});
      chk("dbg_pc", debug_wb_pc, e.dpc);
      chk("fwd_mfc0", {31'b0, ws_fwd_bus[38]}, {31'b0, e.fmfc0});
      chk("fwd_we", {31'b0, ws_fwd_bus[5]}, {31'b0, e.we});
      if (e.we) begin
        chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.wa});
        chk("rf_wdata", rf_wdata, e.wd);
        chk("dbg_wnum", {27'b0, debug_wb_rf_wnum}, {27'b0, e.wa});
        chk("dbg_wdata", debug_wb_rf_wdata, e.wd);
        chk("fwd_data", ws_fwd_bus[37:6], e.wd);
      end
    end
  end

  initial begin
    ms_bus_t b;
    int k;
    reset = 1; ms_to_ws_valid = 0; ms_to_ws_bus = '0;
    model_reset();
    repeat (2) @(posedge clk);
    cyc(1, 0, '0);
    cyc(0, 0, '0);
    // plain commit, dest 0 suppressed
    cyc(0, 1, alu(32'hbfc0_0010, 5'd3, 32'd5));
    cyc(0, 1, alu(32'hbfc0_0014, 5'd0, 32'd7));
    cyc(0, 0, '0);
    // Status write masking
    cyc(0, 1, mtc0_i(32'hbfc0_0020, CP0_STATUS, 32'hffff_ffff));
    cyc(0, 1, mfc0_i(32'hbfc0_0024, 5'd4, CP0_STATUS));
    cyc(0, 1, mtc0_i(32'hbfc0_0028, CP0_STATUS, 32'h0));
    // syscall in delay slot, follower dropped
    cyc(0, 1, exc_i(32'hbfc0_0104, EXC_SYS, 1'b1));
    cyc(0, 1, alu(32'hbfc0_0108, 5'd6, 32'h66));
    cyc(0, 1, alu(32'hbfc0_0380, 5'd7, 32'h77));
    cyc(0, 1, mfc0_i(32'hbfc0_0384, 5'd8, CP0_EPC));
    cyc(0, 1, mfc0_i(32'hbfc0_0388, 5'd9, CP0_CAUSE));
    cyc(0, 1, mfc0_i(32'hbfc0_038c, 5'd10, CP0_STATUS));
    // nested exception then eret
    cyc(0, 1, exc_i(32'hbfc0_0200, EXC_OV, 1'b0));
    cyc(0, 0, '0);
    cyc(0, 1, mfc0_i(32'hbfc0_0390, 5'd11, CP0_EPC));
    cyc(0, 1, mfc0_i(32'hbfc0_0394, 5'd12, CP0_CAUSE));
    cyc(0, 1, eret_i(32'hbfc0_0398));
    cyc(0, 0, '0);
    cyc(0, 1, mfc0_i(32'hbfc0_0100, 5'd13, CP0_STATUS));
    // timer interrupt
    cyc(0, 1, mtc0_i(32'hbfc0_0400, CP0_COUNT, 32'd0));
    cyc(0, 1, mtc0_i(32'hbfc0_0404, CP0_COMPARE, 32'd4));
    cyc(0, 1, mtc0_i(32'hbfc0_0408, CP0_STATUS, 32'h0000_8001));
    repeat (12) cyc(0, 0, '0);
    cyc(0, 1, mfc0_i(32'hbfc0_040c, 5'd14, CP0_CAUSE));
    cyc(0, 1, mtc0_i(32'hbfc0_0410, CP0_COMPARE, 32'h0000_1000));
    cyc(0, 1, mfc0_i(32'hbfc0_0414, 5'd15, CP0_CAUSE));
    cyc(0, 0, '0);
    // count wrap
    cyc(0, 1, mtc0_i(32'hbfc0_0418, CP0_COUNT, 32'hffff_ffff));
    repeat (3) cyc(0, 0, '0);
    cyc(0, 1, mfc0_i(32'hbfc0_041c, 5'd16, CP0_COUNT));
    // reset while exception sits in WS
    cyc(0, 1, exc_i(32'hbfc0_0500, EXC_RI, 1'b0));
    cyc(1, 0, '0);
    cyc(0, 1, mfc0_i(32'hbfc0_0504, 5'd17, CP0_STATUS));
    cyc(0, 0, '0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      b = '0;
      b.pc = $urandom & 32'hffff_fffc;
      b.rt = 5'($urandom);
      b.dest = 5'($urandom);
      b.rt_value = $urandom;
      b.result = $urandom;
      b.gr_we = 1'($urandom);
      k = $urandom_range(0, 99);
      if (k < 35) ;
      else if (k < 52) begin
        b.mtc0 = 1; b.gr_we = 0;
        case ($urandom_range(0, 5))
          0: b.dest = CP0_COUNT; 1: b.dest = CP0_COMPARE; 2: b.dest = CP0_STATUS;
          3: b.dest = CP0_CAUSE; 4: b.dest = CP0_EPC; default: ;
        endcase
      end else if (k < 72) begin
        b.mfc0 = 1;
        if ($urandom_range(0, 3) != 0) b.dest = 5'(9 + $urandom_range(0, 5));
      end else if (k < 78) begin
        b.ex = 1; b.excode = 5'($urandom); b.bd = 1'($urandom);
        b.mtc0 = 1'($urandom); b.eret = 1'($urandom); b.dest = CP0_STATUS;
      end else if (k < 83) b.eret = 1;
      cyc(($urandom_range(0, 99) == 0), (k < 90), b);
    end
    repeat (2) cyc(0, 0, '0);
    @(negedge clk); #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (fifth) pipeline stage: consumes the memory-stage bus, commits GPR writes and hosts the CP0 register file.
- Handles mfc0/mtc0, exception commit and eret, and drives the flush/redirect back to the front end.
- Provides forwarding information and debug trace outputs.

Parameters:
- EX_ENTRY, 32'hbfc0_0380, exception vector.
- COUNT_DIV, 2, cycles per Count increment (1 or 2 only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  memory stage holds a valid instruction
- ms_to_ws_bus  in  117  {ex[116], eret[115], bd[114], excode[113:109], rt[108:104], mfc0[103], mtc0[102], rt_value[101:70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}; for mfc0/mtc0, dest carries CP0 register number (sel=0)
- ws_allowin  out  1  stage can accept
- ws_to_ms_bus  out  1  flush = ws_valid & (ex|eret); memory stage squashes its contents
- ws_flush  out  1  same as ws_to_ms_bus, to fetch/decode/execute
- ws_flush_pc  out  32  EX_ENTRY on ex, EPC on eret
- ws_int_pending  out  1  (Status.IE & !Status.EXL & |(Cause.IP & Status.IM)); decode tags next instruction
- ws_fwd_bus  out  39  {mfc0&ws_valid, rf_wdata, rf_we, rf_waddr} for decode bypass
- rf_we  out  1  GPR write enable
- rf_waddr  out  5  GPR index
- rf_wdata  out  32  GPR data
- debug_wb_pc  out  32  committed pc
- debug_wb_rf_wen  out  4  {4{rf_we}}
- debug_wb_rf_wnum  out  5  = rf_waddr
- debug_wb_rf_wdata  out  32  = rf_wdata

Behaviour:
- Handshake: ready_go=1; ws_allowin = !ws_valid | ready_go.
- Bus register loads when ms_to_ws_valid & ws_allowin.
- ws_valid: reset -> 0; else if ws_allowin, ws_valid <= ms_to_ws_valid & !ws_flush (the instruction arriving behind a flushing one is killed).
- GPR write:
  - rf_we = ws_valid & gr_we & !ex & dest!=0; mfc0: rf_we = ws_valid & !ex & rt!=0.
  - rf_waddr = mfc0 ? rt : dest; rf_wdata = mfc0 ? CP0[dest] : result.
  - Reset: rf_we=0, debug outputs 0 (ws_valid=0).
- CP0 registers (sub-module), reset values:
  - Status(12) = 32'h0040_0000: BEV bit22 reads 1, read-only; IM[15:8], EXL[1], IE[0] rw; other bits read 0.
  - Cause(13) = 0: BD[31], TI[30], IP[15:10] hw (IP7 = TI, IP6..IP2 = 0), IP[9:8] sw rw, ExcCode[6:2].
  - EPC(14) = 0, Count(9) = 0, Compare(11) = 0.
  - Unimplemented numbers read 0 and ignore writes.
- mtc0 write: when ws_valid & mtc0 & !ex, writes rt_value to CP0[dest] masked by writable bits; takes effect next cycle.
- Count and TI:
  - Internal tick toggles each cycle (COUNT_DIV=2); Count increments when tick=1, wrapping 32'hffff_ffff -> 0.
  - mtc0 Count beats the increment in the same cycle and clears tick.
  - TI set when Count==Compare (registered compare); mtc0 Compare clears TI and beats a same-cycle match.
- Exception commit (ws_valid & ex):
  - EXL<=1, ExcCode<=excode.
  - If EXL was 0: BD<=bd, EPC <= bd ? pc-4 : pc. If EXL was 1: BD and EPC unchanged.
  - ws_flush_pc = EX_ENTRY.
  - Exception beats mtc0 and eret in the same instruction.
- eret (ws_valid & eret & !ex): EXL<=0, ws_flush_pc = EPC (value before this cycle's update).
- Flush outputs are combinational from registered state and asserted exactly one cycle per flushing instruction.
- Reset mid-operation clears ws_valid and all CP0 state to reset values; no flush emitted.

Decomposition:
- mycpu.h holds:
  - MS_TO_WS_BUS_WD=117, WS_FWD_BUS_WD=39.
  - CP0 register numbers (9/11/12/13/14).
  - ExcCode constants (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12).
  - EX_ENTRY.
- One sub-module, cp0_regs: register file, Count/Compare/TI logic, exception/eret updates, read mux; wb_stage does the handshake, GPR write and flush.

Test Plan:
- Plain commit: addu pc=bfc0_0010 dest=3 result=5 gr_we=1 -> next cycle rf_we=1, waddr=3, wdata=5, debug_wb_rf_wen=4'hf; dest=0 -> rf_we=0.
- mtc0 Status rt_value=32'hffff_ffff, then mfc0 rt=4 dest=12 -> rf_wdata=32'h0040_ff03.
- Syscall: ex=1 excode=8 bd=1 pc=bfc0_0104 -> ws_flush=1 one cycle, flush_pc=bfc0_0380, EPC=bfc0_0100, Cause.BD=1, ExcCode=8, EXL=1, rf_we=0, following valid instruction dropped.
- Nested exception with EXL=1, pc=bfc0_0200 -> EPC unchanged, ExcCode updated; then eret -> flush_pc = old EPC, EXL=0.
- Timer: mtc0 Count=0, mtc0 Compare=4, Status=32'h0000_8001 -> TI=1 about 8 cycles later, ws_int_pending=1; mtc0 Compare clears TI and int_pending.
- Reset asserted while ex is in WS -> no flush, Status=0040_0000, ws_valid=0 next cycle.
